muldiv_seq: RTL and testbench



---
 rtl/muldiv_seq.sv | 182 ++++++++++++++++++
 tb/tb_muldiv_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative unsigned multiply/divide unit (MUL, MULHU, DIVU, REMU).
// A single N-bit ripple-carry adder is time-shared across all four operations.
// One result bit is produced per clock, so an operation takes N iterations.
// A one-cycle DONE state follows the iterations and presents the result.

// Plain N-bit ripple-carry adder, built from a chain of full adders.
module adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] x_i,
    input  logic [N-1:0] y_i,
    input  logic         cin_i,
    output logic [N-1:0] s_o,
    output logic         cout_o
);

    logic [N:0] carry;

    assign carry[0] = cin_i;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign s_o[i]       = x_i[i] ^ y_i[i] ^ carry[i];
        assign carry[i + 1] = (x_i[i] & y_i[i]) | (x_i[i] & carry[i]) | (y_i[i] & carry[i]);
    end

    assign cout_o = carry[N];

endmodule

module muldiv_seq #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [1:0]   op_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [N-1:0] result_o
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   acc_q, acc_d;
    logic [N-1:0]   q_q, q_d;
    logic [N-1:0]   mb_q, mb_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     op_q, op_d;
    logic [N-1:0]   result_q, result_d;

    // op_q[1] distinguishes divide from multiply; op_q[0] picks the upper half
    // (acc) for MULHU/REMU versus the lower half (q) for MUL/DIVU.
    logic           isDiv;
    logic [N-1:0]   divT;
    logic           divM;
    logic [N-1:0]   addX;
    logic [N-1:0]   addY;
    logic           addCin;
    logic [N-1:0]   addS;
    logic           addCout;
    logic           quotBit;
    logic [N-1:0]   iterAcc;
    logic [N-1:0]   iterQ;

    assign isDiv = op_q[1];

    // Divide: the partial remainder shifted left with the next dividend bit.
    // divM is the bit shifted out, which makes t at least 2^N and therefore
    // always at least the divisor.
    assign divT = {acc_q[N-2:0], q_q[N-1]};
    assign divM = acc_q[N-1];

    // Adder operand steering: shift-add for multiply, trial subtract
    // (t + ~mb + 1) for divide.
    always_comb begin
        addX   = acc_q;
        addY   = '0;
        addCin = 1'b0;
        if (isDiv) begin
            addX   = divT;
            addY   = ~mb_q;
            addCin = 1'b1;
        end else if (q_q[0]) begin
            addY   = mb_q;
        end
    end

    adder #(.N(N)) u_adder (
        .x_i    (addX),
        .y_i    (addY),
        .cin_i  (addCin),
        .s_o    (addS),
        .cout_o (addCout)
    );

    // Value of {acc, q} after one iteration of the current operation.
    always_comb begin
        quotBit = 1'b0;
        iterAcc = {addCout, addS[N-1:1]};
        iterQ   = {addS[0], q_q[N-1:1]};
        if (isDiv) begin
            quotBit = divM | addCout;
            iterAcc = quotBit ? addS : divT;
            iterQ   = {q_q[N-2:0], quotBit};
        end
    end

    // Next-state and datapath update; result is loaded from the final iteration.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        q_d      = q_q;
        mb_d     = mb_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        result_d = result_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    op_d    = op_i;
                    mb_d    = b_i;
                    cnt_d   = CNT_INIT;
                    acc_d   = '0;
                    q_d     = a_i;
                end
            end
            S_RUN: begin
                acc_d = iterAcc;
                q_d   = iterQ;
                if (cnt_q == '0) begin
                    state_d  = S_DONE;
                    result_d = op_q[0] ? iterAcc : iterQ;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            q_q      <= '0;
            mb_q     <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            q_q      <= q_d;
            mb_q     <= mb_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    assign busy_o   = (state_q == S_RUN);
    assign done_o   = (state_q == S_DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vector bench for muldiv_seq with N=32.
// A table of operations with hand-computed results is run in a loop, followed
// by hand-written sequences for held start and reset during an operation.
module tb_muldiv_seq;

    localparam int N = 32;
    localparam int ITER = 32;
    localparam int BOUND = 200;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [1:0]    op;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          busy;
    logic          done;
    logic [N-1:0]  result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expResult;
    } vec_t;

    vec_t vecs[14];

    muldiv_seq #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start),
        .op_i     (op),
        .a_i      (a),
        .b_i      (b),
        .busy_o   (busy),
        .done_o   (done),
        .result_o (result)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Last-resort guard so the run can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Issue one operation from IDLE and wait for done; operands are scrambled
    // right after acceptance to show they were latched.
    task automatic applyStimulus(input logic [1:0] vOp, input logic [31:0] vA, input logic [31:0] vB,
                                 output int edges, output int busyCnt, output bit timedOut);
        start = 1'b1;
        op    = vOp;
        a     = vA;
        b     = vB;
        @(posedge clk);
        #1;
        start    = 1'b0;
        a        = $urandom;
        b        = $urandom;
        op       = 2'($urandom_range(0, 3));
        edges    = 0;
        busyCnt  = 0;
        timedOut = 1'b0;
        while (!done && !timedOut) begin
            if (busy) busyCnt++;
            @(posedge clk);
            #1;
            edges++;
            if (edges > BOUND) timedOut = 1'b1;
        end
    endtask

    initial begin
        int  edges;
        int  busyCnt;
        bit  timedOut;

        vecs[0]  = '{"mul 7x6",          2'b00, 32'd7,          32'd6,          32'd42};
        vecs[1]  = '{"mulhu max",        2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE};
        vecs[2]  = '{"mul max",          2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001};
        vecs[3]  = '{"divu 100/7",       2'b10, 32'd100,        32'd7,          32'd14};
        vecs[4]  = '{"remu 100/7",       2'b11, 32'd100,        32'd7,          32'd2};
        vecs[5]  = '{"divu msb/1",       2'b10, 32'h8000_0000,  32'd1,          32'h8000_0000};
        vecs[6]  = '{"divu by zero",     2'b10, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF};
        vecs[7]  = '{"remu by zero",     2'b11, 32'h0000_1234,  32'd0,          32'h0000_1234};
        vecs[8]  = '{"mulhu 2^31x4",     2'b01, 32'h8000_0000,  32'd4,          32'h0000_0002};
        vecs[9]  = '{"mul wrap",         2'b00, 32'h1234_5678,  32'h10,         32'h2345_6780};
        vecs[10] = '{"remu max/16",      2'b11, 32'hFFFF_FFFF,  32'h10,         32'h0000_000F};
        vecs[11] = '{"divu 5/7",         2'b10, 32'd5,          32'd7,          32'd0};
        vecs[12] = '{"remu 5/7",         2'b11, 32'd5,          32'd7,          32'd5};
        vecs[13] = '{"divu max/max",     2'b10, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1};

        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        #12;
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset result", result, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, edges, busyCnt, timedOut);
            checkOutput({vecs[i].name, " timeout"}, 32'(timedOut), 32'd0);
            checkOutput({vecs[i].name, " result"}, result, vecs[i].expResult);
            checkOutput({vecs[i].name, " latency"}, 32'(edges + 1), 32'd33);
            checkOutput({vecs[i].name, " busy cycles"}, 32'(busyCnt), 32'd32);
            checkOutput({vecs[i].name, " busy with done"}, 32'(busy), 32'd0);
            @(posedge clk);
            #1;
            checkOutput({vecs[i].name, " done pulse"}, 32'(done), 32'd0);
            checkOutput({vecs[i].name, " idle busy"}, 32'(busy), 32'd0);
        end

        // Start held high with changing operands throughout RUN and DONE.
        start = 1'b1;
        op    = 2'b00;
        a     = 32'd7;
        b     = 32'd6;
        @(posedge clk);
        #1;
        op    = 2'b11;
        edges = 0;
        while (!done && edges <= BOUND) begin
            a = $urandom;
            b = $urandom;
            @(posedge clk);
            #1;
            edges++;
        end
        checkOutput("held first result", result, 32'd42);
        checkOutput("held first edges", 32'(edges), 32'(ITER));
        op = 2'b10;
        a  = 32'd100;
        b  = 32'd7;
        @(posedge clk);
        #1;
        checkOutput("held idle busy", 32'(busy), 32'd0);
        checkOutput("held idle done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("held next accepted", 32'(busy), 32'd1);
        checkOutput("held result kept", result, 32'd42);
        start = 1'b0;
        edges = 0;
        while (!done && edges <= BOUND) begin
            @(posedge clk);
            #1;
            edges++;
        end
        checkOutput("held second result", result, 32'd14);
        checkOutput("held second edges", 32'(edges), 32'(ITER));
        @(posedge clk);
        #1;

        // Reset pulsed after iteration 10 aborts the operation immediately.
        start = 1'b1;
        op    = 2'b00;
        a     = 32'd9;
        b     = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("pre-reset busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort done", 32'(done), 32'd0);
        checkOutput("abort result", result, 32'd0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("after reset idle", 32'(busy), 32'd0);
        applyStimulus(2'b00, 32'd3, 32'd5, edges, busyCnt, timedOut);
        checkOutput("mul 3x5 timeout", 32'(timedOut), 32'd0);
        checkOutput("mul 3x5 result", result, 32'd15);
        checkOutput("mul 3x5 latency", 32'(edges + 1), 32'd33);
        checkOutput("mul 3x5 busy cycles", 32'(busyCnt), 32'd32);
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
